irq_arbiter: RTL

- Prioritised interrupt arbiter between external sources (keyboard, UART, timer, ...) and the riscv64 core's single interrupt input.
- Latches source edges into pending bits and masks them with a bus-programmable enable register.
- Presents one vector at a time to the core, then tracks the handshake through ack and mret.
- Sits on the CPU memory bus as a small slave alongside the Key/Art peripherals.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_prio_enc.sv | 21 ++
 rtl/irq_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM states,
// register offsets within the bus block and the vector encoding.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam int VEC_W = 4;
  localparam logic [VEC_W-1:0] VEC_NONE = '0;

  // Offsets are decoded from the low 5 address bits of a 32-byte block
  localparam logic [4:0] OFF_PENDING = 5'h00;
  localparam logic [4:0] OFF_ENABLE  = 5'h08;
  localparam logic [4:0] OFF_ACTIVE  = 5'h10;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder for the arbiter.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [VEC_W-1:0]   idx
);

  always_comb begin
    idx = '0;
    // Scan downward so the lowest set index is the final assignment
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = VEC_W'(i);
    end
    valid = |req;
  end

endmodule

// File: rtl/irq_arbiter.sv
// Prioritised interrupt arbiter with a small bus register block.
// Define IRQ_ARB_SYNC_EN to pass irq_src through a 2-flop synchroniser.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int                 NUM_SRC    = 4,
  parameter logic [63:0]        BASE_ADDR  = 64'h0000_3000,
  parameter logic [NUM_SRC-1:0] ENABLE_RST = NUM_SRC'(1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic [VEC_W-1:0]   interrupt_vector,
  input  logic               interrupt_ack,
  input  logic               interrupt_pending,
  input  logic [63:0]        bus_address,
  input  logic [63:0]        bus_write_data,
  input  logic               bus_write_enable,
  input  logic               bus_read_enable,
  output logic [63:0]        bus_read_data
);

  // Core handshake: the vector is held stable in REQ until a one-cycle
  // interrupt_ack; a 1->0 transition of interrupt_pending marks mret.

  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic               ip_q;
  irq_state_e         state, state_d;
  logic [VEC_W-1:0]   win, win_d;
  logic [VEC_W-1:0]   vec_d;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] win_mask;
  logic               req_valid;
  logic [VEC_W-1:0]   req_idx;

`ifdef IRQ_ARB_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  assign src_s = sync2;
`else
  assign src_s = irq_src;
`endif

  logic               hit;
  logic [4:0]         off;
  logic               wr_pend, wr_en;
  logic [NUM_SRC-1:0] edges;
  logic [VEC_W-1:0]   active;

  assign hit     = (bus_address[63:5] == BASE_ADDR[63:5]);
  assign off     = bus_address[4:0];
  assign wr_pend = bus_write_enable & hit & (off == OFF_PENDING);
  assign wr_en   = bus_write_enable & hit & (off == OFF_ENABLE);
  assign edges   = src_s & ~src_q;
  assign win_mask = NUM_SRC'(1) << win;
  assign active  = (state != IDLE) ? win + VEC_W'(1) : VEC_NONE;

  irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .req   (pending & enable),
    .valid (req_valid),
    .idx   (req_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      win              <= '0;
      interrupt_vector <= VEC_NONE;
    end else begin
      state            <= state_d;
      win              <= win_d;
      interrupt_vector <= vec_d;
    end
  end

  always_comb begin
    state_d = state;
    win_d   = win;
    vec_d   = interrupt_vector;
    ack_clr = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          win_d   = req_idx;
          vec_d   = req_idx + VEC_W'(1);
          state_d = REQ;
        end
      end
      REQ: begin
        if (interrupt_ack) begin
          ack_clr = win_mask;
          vec_d   = VEC_NONE;
          state_d = SERVICE;
        end else if ((enable & win_mask) == '0) begin
          // Source masked while presented: withdraw but keep it pending
          vec_d   = VEC_NONE;
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (ip_q && !interrupt_pending) state_d = IDLE;
      end
      default: begin
        vec_d   = VEC_NONE;
        state_d = IDLE;
      end
    endcase
  end

  // Edge sets take precedence over both W1C and ack clears
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '0;
      ip_q    <= 1'b0;
      pending <= '0;
      enable  <= ENABLE_RST;
    end else begin
      src_q   <= src_s;
      ip_q    <= interrupt_pending;
      pending <= (pending & ~(wr_pend ? bus_write_data[NUM_SRC-1:0] : '0) & ~ack_clr) | edges;
      if (wr_en) enable <= bus_write_data[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_read_data <= '0;
    end else if (bus_read_enable && hit) begin
      case (off)
        OFF_PENDING: bus_read_data <= 64'(pending);
        OFF_ENABLE:  bus_read_data <= 64'(enable);
        OFF_ACTIVE:  bus_read_data <= 64'(active);
        default:     bus_read_data <= '0;
      endcase
    end
  end

endmodule
